mux_scan_ctrl: RTL and testbench

Channel scanner that drives the select lines of a `mux_41` instance and consumes its single-bit output. It steps `sel` through channels 0..3, waits a programmable settle time on each, captures `Y`, and presents the reassembled 4-bit word on a valid/ready output handshake. It sits directly around `mux_41`: `sel` feeds the mux, and the mux `Y` returns as `y_in`.

---
 rtl/mux_scan_ctrl_pkg.sv | 14 +
 rtl/mux_41.sv | 12 +
 rtl/mux_scan_ctrl.sv | 105 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux_41 channel scanner: channel count, select width
// and controller state encoding.
package mux_scan_ctrl_pkg;

   localparam int NCH   = 4;
   localparam int SEL_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

endpackage

// File: rtl/mux_41.sv
// Combinational 4:1 multiplexer scanned by mux_scan_ctrl.
module mux_41
   import mux_scan_ctrl_pkg::*;
(
   input  logic [SEL_W-1:0] sel,
   input  logic [NCH-1:0]   I,
   output logic             Y
);

   assign Y = I[sel];

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps mux_41 select through all channels, samples Y after a settle time on each,
// and offers the reassembled word on a valid/ready handshake.
module mux_scan_ctrl
   import mux_scan_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cont,
   input  logic             y_in,
   output logic [SEL_W-1:0] sel,
   output logic [NCH-1:0]   word,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             busy
);

   localparam logic [3:0]       SETTLE_C = 4'(SETTLE);
   localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(NCH - 1);

   state_t           state_reg, state_next;
   logic [SEL_W-1:0] sel_reg;
   logic [SEL_W-1:0] ch_reg;
   logic [3:0]       cnt_reg;
   logic [NCH-2:0]   shadow_reg;
   logic [NCH-1:0]   word_reg;
   logic             sample_now;
   logic             last_sample;

   assign sample_now  = (state_reg == ST_WAIT) && (cnt_reg == SETTLE_C);
   assign last_sample = sample_now && (ch_reg == CH_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start)       state_next = ST_WAIT;
         ST_WAIT: if (last_sample) state_next = ST_OUT;
         ST_OUT:  if (word_ready)  state_next = cont ? ST_WAIT : ST_IDLE;
         default:                  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_reg != ST_IDLE);
      word_valid = (state_reg == ST_OUT);
   end

   // y_in comes from a same-clock combinational mux, so it is sampled raw.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_reg    <= '0;
         ch_reg     <= '0;
         cnt_reg    <= '0;
         shadow_reg <= '0;
         word_reg   <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  sel_reg <= '0;
                  ch_reg  <= '0;
                  cnt_reg <= '0;
               end
            end
            ST_WAIT: begin
               if (!sample_now) begin
                  cnt_reg <= cnt_reg + 4'd1;
               end else begin
                  cnt_reg <= '0;
                  if (ch_reg != CH_LAST) begin
                     shadow_reg[ch_reg] <= y_in;
                     ch_reg             <= ch_reg + 1'b1;
                     sel_reg            <= ch_reg + 1'b1;
                  end else begin
                     word_reg <= {y_in, shadow_reg};
                  end
               end
            end
            ST_OUT: begin
               // Both the restart and the return to idle park sel on channel 0.
               if (word_ready) begin
                  sel_reg <= '0;
                  ch_reg  <= '0;
                  cnt_reg <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign sel  = sel_reg;
   assign word = word_reg;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench: two scanner+mux pairs (SETTLE=1 at index 0, SETTLE=0 at index 1)
// checked against a timing-rule reference model.
module tb_mux_scan_ctrl;

   typedef struct {
      logic [3:0] word;
      int         base;
      int         lat;
   } entry_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cont = 1'b0;
   logic       word_ready = 1'b0;
   logic [3:0] mux_i = 4'd0;
   logic       start_a [2];
   logic       y_a     [2];
   logic [1:0] sel_a   [2];
   logic [3:0] word_a  [2];
   logic       wv_a    [2];
   logic       busy_a  [2];

   entry_t     q0[$];
   entry_t     q1[$];
   logic [3:0] plan[$];
   int         n_checks = 0;
   int         n_fail = 0;
   int         edge_cnt = 0;

   bit         prev_v   [2];
   int         last_acc [2];
   logic [3:0] held     [2];
   int         post_acc [2];

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   mux_41 u_mux_s1 (.sel(sel_a[0]), .I(mux_i), .Y(y_a[0]));
   mux_scan_ctrl #(.SETTLE(1)) u_dut_s1 (
      .clk(clk), .rst_n(rst_n), .start(start_a[0]), .cont(cont), .y_in(y_a[0]),
      .sel(sel_a[0]), .word(word_a[0]), .word_valid(wv_a[0]),
      .word_ready(word_ready), .busy(busy_a[0]));

   mux_41 u_mux_s0 (.sel(sel_a[1]), .I(mux_i), .Y(y_a[1]));
   mux_scan_ctrl #(.SETTLE(0)) u_dut_s0 (
      .clk(clk), .rst_n(rst_n), .start(start_a[1]), .cont(cont), .y_in(y_a[1]),
      .sel(sel_a[1]), .word(word_a[1]), .word_valid(wv_a[1]),
      .word_ready(word_ready), .busy(busy_a[1]));

   function automatic int settle_of(input int k);
      return (k == 0) ? 1 : 0;
   endfunction

   task automatic check(input string name, input int k, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0d expected %0d at edge %0d", name, k, act, exp, edge_cnt);
      end
   endtask

   task automatic push(input int k, input entry_t e);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Monitor: pops an expectation whenever a new word appears, and checks sel
   // against the channel timing rule while a scan is expected to be running.
   always @(negedge clk) begin
      entry_t e;
      int     qn, b, rel, s;
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            prev_v[k]   = 1'b0;
            post_acc[k] = 0;
         end else begin
            s  = settle_of(k);
            qn = (k == 0) ? q0.size() : q1.size();
            if (post_acc[k] == 1) begin
               check("idle_busy", k, busy_a[k], 0);
               check("idle_sel", k, sel_a[k], 0);
               check("idle_valid", k, wv_a[k], 0);
            end else if (post_acc[k] == 2) begin
               check("cont_busy", k, busy_a[k], 1);
               check("cont_sel", k, sel_a[k], 0);
               check("cont_valid", k, wv_a[k], 0);
            end
            post_acc[k] = 0;
            if (wv_a[k] && !prev_v[k]) begin
               if (qn == 0) begin
                  check("unexpected_word", k, 1, 0);
               end else begin
                  e = (k == 0) ? q0.pop_front() : q1.pop_front();
                  b = (e.base < 0) ? last_acc[k] : e.base;
                  check("word", k, word_a[k], e.word);
                  check("rise_edge", k, edge_cnt, b + e.lat);
               end
               held[k] = word_a[k];
            end
            if (wv_a[k]) begin
               check("hold_word", k, word_a[k], held[k]);
               check("hold_sel", k, sel_a[k], 3);
               check("hold_busy", k, busy_a[k], 1);
               if (word_ready) begin
                  last_acc[k] = edge_cnt + 1;
                  post_acc[k] = cont ? 2 : 1;
               end
            end else if (qn > 0) begin
               e   = (k == 0) ? q0[0] : q1[0];
               b   = (e.base < 0) ? last_acc[k] : e.base;
               rel = edge_cnt - b;
               if (rel >= 0 && rel < 4 * (s + 1)) begin
                  check("scan_sel", k, sel_a[k], rel / (s + 1));
                  check("scan_busy", k, busy_a[k], 1);
               end
            end
            prev_v[k] = wv_a[k];
         end
      end
   end

   task automatic wait_idle(input int k);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!busy_a[k]) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) check("idle_timeout", k, 0, 1);
   endtask

   task automatic wait_valid(input int k, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (wv_a[k]) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_plan(input int k, input bit cont_mode, input int stall_fix);
      int n, lat, stall;
      bit ok;
      n   = plan.size();
      lat = 4 * (settle_of(k) + 1);
      wait_idle(k);
      mux_i = plan[0];
      @(posedge clk); #1;
      start_a[k] = 1'b1;
      cont       = cont_mode;
      push(k, '{word: plan[0], base: edge_cnt + 1, lat: lat});
      @(posedge clk); #1;
      start_a[k] = 1'b0;
      // A start pulse while busy must not disturb the scan in progress.
      @(posedge clk); #1;
      start_a[k] = 1'b1;
      @(posedge clk); #1;
      start_a[k] = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i + 1 < n) push(k, '{word: plan[i+1], base: -1, lat: lat});
         wait_valid(k, ok);
         if (!ok) begin
            check("valid_timeout", k, 0, 1);
            cont = 1'b0;
            return;
         end
         stall = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 4));
         repeat (stall) begin
            @(posedge clk); #1;
         end
         cont       = cont_mode && (i + 1 < n);
         word_ready = 1'b1;
         @(posedge clk); #1;
         word_ready = 1'b0;
         if (i + 1 < n) mux_i = plan[i+1];
      end
      cont = 1'b0;
   endtask

   initial begin
      int  k, n;
      bit  ok;
      start_a[0] = 1'b0;
      start_a[1] = 1'b0;
      rst_n      = 1'b0;

      // Reset holds everything cleared despite random inputs.
      repeat (5) begin
         @(posedge clk); #1;
         start_a[0] = 1'($urandom);
         start_a[1] = 1'($urandom);
         cont       = 1'($urandom);
         word_ready = 1'($urandom);
         mux_i      = 4'($urandom);
         @(negedge clk);
         for (int j = 0; j < 2; j++) begin
            check("rst_sel", j, sel_a[j], 0);
            check("rst_word", j, word_a[j], 0);
            check("rst_valid", j, wv_a[j], 0);
            check("rst_busy", j, busy_a[j], 0);
         end
      end
      @(posedge clk); #1;
      start_a[0] = 1'b0;
      start_a[1] = 1'b0;
      cont       = 1'b0;
      word_ready = 1'b0;
      rst_n      = 1'b1;

      plan = '{4'b0100};
      run_plan(0, 1'b0, 0);
      plan = '{4'b0100};
      run_plan(0, 1'b0, 5);
      plan = '{4'b1010, 4'b0011};
      run_plan(0, 1'b1, -1);
      plan = '{4'b1000};
      run_plan(1, 1'b0, -1);

      // Asynchronous reset in the middle of a scan, on channel 2.
      wait_idle(0);
      mux_i = 4'b1110;
      @(posedge clk); #1;
      start_a[0] = 1'b1;
      push(0, '{word: mux_i, base: edge_cnt + 1, lat: 8});
      @(posedge clk); #1;
      start_a[0] = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (sel_a[0] == 2'd2) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("reach_sel2", 0, ok, 1);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("async_sel", 0, sel_a[0], 0);
      check("async_word", 0, word_a[0], 0);
      check("async_busy", 0, busy_a[0], 0);
      check("async_valid", 0, wv_a[0], 0);
      q0.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      plan = '{4'b0110};
      run_plan(0, 1'b0, -1);

      repeat (30) begin
         k = int'($urandom_range(0, 1));
         n = int'($urandom_range(1, 3));
         plan.delete();
         for (int i = 0; i < n; i++) plan.push_back(4'($urandom));
         run_plan(k, n > 1, -1);
      end

      repeat (4) @(posedge clk);
      #1;
      check("queue_drained", 0, q0.size() + q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
